regfile_writeback: RTL
======================

// Module: regfile_writeback
// PURPOSE
//  Writer side of the RegFile write port (i_wdata/i_waddr/i_wen). Merges two result producers,
//  the single-cycle ALU and the handshaked load unit, into one registered write per cycle.
//  Holds a load-result FIFO and a pending-load scoreboard that tells issue/decode which
//  registers are not yet valid. Sits between execute/LSU and RegFile in the rv32i core.
// PARAMETERS
//  XLEN      32  data width of a register
//  NREG      32  number of architectural registers (addr width = $clog2(NREG) = 5)
//  LQ_DEPTH  2   load-result FIFO entries (power of two, >=2)
// PORTS
//  i_clk         in   1     core clock, rising edge
//  i_rst         in   1     asynchronous, active-high reset
//  i_issue_valid in   1     an instruction is issued this cycle
//  i_issue_load  in   1     issued instruction is a load (qualifies scoreboard set)
//  i_issue_rd    in   5     destination of issued instruction
//  o_rd_busy     out  1     busy[i_issue_rd]; issuer must stall any instr writing a busy rd
//  i_alu_valid   in   1     ALU result valid (no ready; always accepted)
//  i_alu_rd      in   5     ALU destination
//  i_alu_data    in   XLEN  ALU result
//  i_ld_valid    in   1     load result valid
//  o_ld_ready    out  1     load result accepted when valid&&ready
//  i_ld_rd       in   5     load destination
//  i_ld_data     in   XLEN  load data
//  o_wen         out  1     to RegFile i_wen
//  o_waddr       out  5     to RegFile i_waddr
//  o_wdata       out  XLEN  to RegFile i_wdata
//  i_r1addr      in   5     decode source 1 address
//  i_r2addr      in   5     decode source 2 address
//  o_r1_busy     out  1     busy[i_r1addr]
//  o_r2_busy     out  1     busy[i_r2addr]
// BEHAVIOUR
//  - Reset (async): o_wen=0, o_waddr=0, o_wdata=0, busy[]=0, FIFO empty -> o_ld_ready=1.
//  - Write port fully registered. ALU priority: i_alu_valid at edge N -> o_wen=1 in cycle N..N+1.
//  - Loads always enter FIFO on valid&&ready. FIFO head pops into write register in any cycle
//    with i_alu_valid=0 and FIFO non-empty. Min load latency 2 cycles; FIFO order preserved.
//  - o_ld_ready = !full (registered count only; no same-cycle pop pass-through when full).
//  - rd==0: never written (o_wen stays 0, slot not consumed beyond the pop), never busy.
//    o_r1_busy/o_r2_busy/o_rd_busy are 0 for addr 0.
//  - Scoreboard: i_issue_valid&&i_issue_load&&rd!=0 sets busy[rd] at edge. Clear busy[rd] at the
//    edge that loads o_wen=1 for that load. Set and clear of same rd in same edge: set wins.
//  - Load result for non-busy rd: still written; scoreboard unchanged.
//  - Busy outputs are combinational from busy[] (no write-to-read bypass; RegFile forwarding
//    is out of scope). ALU results are not tracked.
//  - Issue of load to an already-busy rd is a protocol error (issuer stalls on o_rd_busy);
//    bench asserts it never occurs.
//  - Reset mid-operation: all FIFO contents and busy bits discarded, o_wen drops immediately.
// STRUCTURE
//  - Package rv32i_pkg: XLEN, REG_AW=5, NREG, typedef wb_req_t {logic [4:0] rd; logic [XLEN-1:0] data;}.
//  - Sub-module wb_fifo (sync FIFO of wb_req_t, LQ_DEPTH, push/pop/full/empty, async reset).
//  - Top: scoreboard vector, ALU/FIFO select mux, output register.
// TESTING
//  1 ALU write: alu rd=0x12 data=0xdeadbeef one cycle -> next cycle o_wen=1, waddr=0x12,
//    wdata=0xdeadbeef; RegFile readback on r1addr=0x12 returns 0xdeadbeef.
//  2 Load scoreboard: issue load rd=0x13 -> o_r1_busy=1 (r1addr=0x13) next cycle; ld rd=0x13
//    data=0xbabecafe accepted -> o_wen 2 cycles later, busy clears at that edge.
//  3 Collision: alu rd=5 0x11111111 and ld rd=6 0x22222222 same cycle -> rd5 written cycle+1,
//    rd6 written cycle+2.
//  4 Backpressure: ALU valid 4 consecutive cycles, 3 loads offered back-to-back -> 2 accepted,
//    o_ld_ready=0 until ALU idles; all 3 loads written afterwards in order.
//  5 x0: alu rd=0 0xbbc0ffee -> o_wen stays 0; issue load rd=0 -> o_rd_busy stays 0;
//    alu rd=1 0xefbeadde -> written normally.
//  6 Reset mid-op: FIFO full, busy[7]=1, o_wen=1 -> assert i_rst between edges: o_wen=0, busy=0,
//    o_ld_ready=1 immediately; no write appears after release.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared types and sizes for the rv32i core write-back path.
//   XLEN     : register data width
//   NREG     : number of architectural registers
//   REG_AW   : register address width
//   LQ_DEPTH : default depth of the load-result FIFO
//   wb_req_t : one pending register write (destination + data)
package rv32i_pkg;

  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int REG_AW   = $clog2(NREG);
  localparam int LQ_DEPTH = 2;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back requests used to park load results
// until the write port is free.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_push       : write i_data (ignored when full)
//   i_pop        : discard the head entry (ignored when empty)
//   o_data       : head entry, valid while !o_empty
//   o_full       : no free slot
//   o_empty      : no entry stored
module wb_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = LQ_DEPTH
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_push,
  input  wb_req_t i_data,
  input  logic    i_pop,
  output wb_req_t o_data,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  wb_req_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            push_ok, pop_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  // Head is read straight from storage so the writer can take it this cycle.
  assign o_data  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back stage: merges ALU results (always accepted, highest priority)
// and handshaked load results (buffered in a FIFO) into a single registered
// RegFile write per cycle, and tracks which registers await a load.
//   i_clk, i_rst                 : clock, asynchronous active-high reset
//   i_issue_*                    : issue-time load tracking (sets busy[rd])
//   o_rd_busy/o_r1_busy/o_r2_busy: busy lookups for issue and decode
//   i_alu_*                      : ALU result, no backpressure
//   i_ld_* / o_ld_ready          : load result handshake
//   o_wen/o_waddr/o_wdata        : registered RegFile write port
module regfile_writeback
  import rv32i_pkg::*;
#(
  parameter int LQ = LQ_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_issue_valid,
  input  logic              i_issue_load,
  input  logic [REG_AW-1:0] i_issue_rd,
  output logic              o_rd_busy,
  input  logic              i_alu_valid,
  input  logic [REG_AW-1:0] i_alu_rd,
  input  logic [XLEN-1:0]   i_alu_data,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [REG_AW-1:0] i_ld_rd,
  input  logic [XLEN-1:0]   i_ld_data,
  output logic              o_wen,
  output logic [REG_AW-1:0] o_waddr,
  output logic [XLEN-1:0]   o_wdata,
  input  logic [REG_AW-1:0] i_r1addr,
  input  logic [REG_AW-1:0] i_r2addr,
  output logic              o_r1_busy,
  output logic              o_r2_busy
);

  wb_req_t           ld_req;
  wb_req_t           head;
  logic              fifo_full, fifo_empty;
  logic              push, pop;

  logic              wen_q,   wen_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [NREG-1:0]   busy_q,  busy_d;

  assign ld_req.rd   = i_ld_rd;
  assign ld_req.data = i_ld_data;

  // Ready comes only from the registered occupancy: a full FIFO refuses a
  // new load even in a cycle where it is popping.
  assign o_ld_ready = !fifo_full;
  assign push       = i_ld_valid && !fifo_full;
  // The ALU owns the write port whenever it has a result.
  assign pop        = !i_alu_valid && !fifo_empty;

  wb_fifo #(.DEPTH(LQ)) u_lq (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (ld_req),
    .i_pop   (pop),
    .o_data  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    if (i_alu_valid) begin
      if (i_alu_rd != '0) begin
        wen_d   = 1'b1;
        waddr_d = i_alu_rd;
        wdata_d = i_alu_data;
      end
    end else if (pop) begin
      // An x0 load is still drained from the FIFO but produces no write.
      if (head.rd != '0) begin
        wen_d          = 1'b1;
        waddr_d        = head.rd;
        wdata_d        = head.data;
        busy_d[head.rd] = 1'b0;
      end
    end
    // Applied after the clear so a same-edge re-issue keeps the bit set.
    if (i_issue_valid && i_issue_load && (i_issue_rd != '0))
      busy_d[i_issue_rd] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign o_wen   = wen_q;
  assign o_waddr = waddr_q;
  assign o_wdata = wdata_q;

  // busy_q[0] can never be set, so x0 always reads as not busy.
  assign o_rd_busy = busy_q[i_issue_rd];
  assign o_r1_busy = busy_q[i_r1addr];
  assign o_r2_busy = busy_q[i_r2addr];

endmodule
